start_stop_ctrl: RTL and testbench
==================================

START_STOP_CTRL -- requirements
Module: start_stop_ctrl

Interface
REQ-001 The block SHALL have a parameter DB_CNT, default 500000, giving the number of consecutive clk cycles a synchronized button level must differ from its debounced level before being accepted (10 ms at 50 MHz); legal range 2..2^20.
REQ-002 The block SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-003 The block SHALL have port clk, input, 1 bit, single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port btn_start, input, 1 bit, raw asynchronous start/stop push button, active-high.
REQ-005 The block SHALL have port btn_clear, input, 1 bit, raw asynchronous clear push button, active-high.
REQ-006 The block SHALL have port btn_lap, input, 1 bit, raw asynchronous lap push button, active-high, used only under LAP_EN.
REQ-007 The block SHALL have port start_stop, output, 1 bit, registered run enable that gates the stopwatch counters.
REQ-008 The block SHALL have port clear_pulse, output, 1 bit, registered one-cycle counter clear request.
REQ-009 The block SHALL have port lap_hold, output, 1 bit, registered display-freeze level.
REQ-010 The block SHALL have port state_o, output, 2 bits, current FSM state: IDLE=00, RUN=01, PAUSE=10.

Function
REQ-011 Each button SHALL pass through a two-flop synchronizer before any other use.
REQ-012 Each button SHALL have its own debouncer: counter clears when synced level equals debounced level, else increments; on the DB_CNT-th consecutive differing cycle the debounced level takes the synced level and the counter clears.
REQ-013 A glitch shorter than DB_CNT cycles SHALL leave the debounced level unchanged.
REQ-014 A press SHALL be a registered one-cycle pulse on the debounced 0->1 edge; releases SHALL generate nothing.
REQ-015 Total latency from the first edge sampling a held button high to the resulting output change SHALL be exactly DB_CNT+4 edges: 2 sync, DB_CNT debounce, 1 pulse, 1 FSM/output.
REQ-016 FSM on start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
REQ-017 FSM on clear press: PAUSE->IDLE, IDLE->IDLE; RUN ignores it.
REQ-018 clear_pulse SHALL be high for exactly one cycle, on the same cycle state_o becomes IDLE via clear; a clear press in IDLE also pulses it.
REQ-019 Same-cycle start and clear presses: in IDLE or PAUSE, clear wins (IDLE, clear_pulse); in RUN, start wins (PAUSE, no clear_pulse).
REQ-020 start_stop SHALL be 1 iff state_o is RUN, updated on the same edge as state_o.
REQ-021 A button held indefinitely SHALL produce exactly one press.

Reset
REQ-022 On rst high at a clk edge: state_o=IDLE, start_stop=0, clear_pulse=0, lap_hold=0, synchronizers, debounced levels and counters all 0.
REQ-023 Reset mid-debounce or mid-RUN SHALL discard the pending press and return to IDLE. A button still held after reset SHALL produce a press after DB_CNT+4 edges.

Configuration
REQ-024 With macro STOPWATCH_LAP_EN defined, btn_lap SHALL be synchronized and debounced like the others. A lap press in RUN toggles lap_hold. A lap press in PAUSE clears lap_hold. Entering IDLE clears lap_hold. A lap press in IDLE is ignored.
REQ-025 Without STOPWATCH_LAP_EN, btn_lap SHALL be ignored and lap_hold SHALL be constant 0; the port list is unchanged.

Verification (DB_CNT=4)
REQ-026 Start press: btn_start high 20 cycles from IDLE -> start_stop rises exactly 8 edges after the first high sample, state_o=01.
REQ-027 Glitch: btn_start high 3 cycles -> no change on start_stop or state_o.
REQ-028 Start twice, then clear -> RUN, PAUSE, then IDLE with clear_pulse high exactly 1 cycle. A clear pressed during RUN -> no pulse, state stays 01.
REQ-029 Simultaneous press: btn_start and btn_clear rise together in PAUSE -> IDLE plus clear_pulse. Same stimulus in RUN -> PAUSE, no clear_pulse.
REQ-030 Reset: rst asserted 1 cycle while in RUN with a start press half-debounced -> all outputs 0, state 00, no later press from the aborted debounce.
REQ-031 LAP_EN on: lap pressed twice in RUN -> lap_hold 1 then 0; lap then clear via PAUSE -> lap_hold 0 in IDLE. LAP_EN off: lap_hold stays 0 throughout.

Source files
------------

// File: rtl/start_stop_ctrl.sv
// Stopwatch start/stop/clear controller: per-button sync + debounce + press edge, then a 3-state FSM.
// Optional lap/display-freeze feature enabled by defining STOPWATCH_LAP_EN.
module start_stop_ctrl #(
    parameter int unsigned DB_CNT = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_start,
    input  logic       btn_clear,
    input  logic       btn_lap,
    output logic       start_stop,
    output logic       clear_pulse,
    output logic       lap_hold,
    output logic [1:0] state_o
);

    localparam int unsigned CW = $clog2(DB_CNT);

`ifdef STOPWATCH_LAP_EN
    localparam int unsigned NB = 3;
    logic [NB-1:0] raw;
    assign raw = {btn_lap, btn_clear, btn_start};
`else
    localparam int unsigned NB = 2;
    logic [NB-1:0] raw;
    logic          unused_lap;
    assign raw        = {btn_clear, btn_start};
    assign unused_lap = btn_lap;
`endif

    logic [NB-1:0] press;

    for (genvar i = 0; i < NB; i++) begin : g_btn
        logic          sync1;
        logic          sync2;
        logic          db;
        logic          db_prev;
        logic          press_q;
        logic [CW-1:0] cnt;

        // Debounce: level must disagree for DB_CNT consecutive cycles to be accepted.
        always_ff @(posedge clk) begin
            if (rst) begin
                sync1   <= 1'b0;
                sync2   <= 1'b0;
                db      <= 1'b0;
                db_prev <= 1'b0;
                press_q <= 1'b0;
                cnt     <= '0;
            end else begin
                sync1   <= raw[i];
                sync2   <= sync1;
                db_prev <= db;
                press_q <= db & ~db_prev;
                if (sync2 == db) begin
                    cnt <= '0;
                end else if (cnt == CW'(DB_CNT - 1)) begin
                    db  <= sync2;
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end

        assign press[i] = press_q;
    end

    logic press_start;
    logic press_clear;
    logic press_lap;

    assign press_start = press[0];
    assign press_clear = press[1];
`ifdef STOPWATCH_LAP_EN
    assign press_lap   = press[2];
`else
    assign press_lap   = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   clear_d;
    logic   lap_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            start_stop  <= 1'b0;
            clear_pulse <= 1'b0;
            lap_hold    <= 1'b0;
        end else begin
            state_q     <= state_d;
            start_stop  <= (state_d == RUN);
            clear_pulse <= clear_d;
            lap_hold    <= lap_d;
        end
    end

    // Clear beats start in IDLE/PAUSE; in RUN clear is ignored so start wins.
    always_comb begin
        state_d = state_q;
        clear_d = 1'b0;
        lap_d   = lap_hold;
        case (state_q)
            IDLE: begin
                if (press_clear) begin
                    clear_d = 1'b1;
                end else if (press_start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (press_start) begin
                    state_d = PAUSE;
                end
                if (press_lap) begin
                    lap_d = ~lap_hold;
                end
            end
            PAUSE: begin
                if (press_clear) begin
                    state_d = IDLE;
                    clear_d = 1'b1;
                end else if (press_start) begin
                    state_d = RUN;
                end
                if (press_lap) begin
                    lap_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == IDLE) begin
            lap_d = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_start_stop_ctrl.sv
// Directed self-checking bench for start_stop_ctrl with DB_CNT=4 (press latency 8 edges).
module tb_start_stop_ctrl;

    localparam int unsigned DB = 4;
    localparam int unsigned LAT = DB + 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       btn_start;
    logic       btn_clear;
    logic       btn_lap;
    logic       start_stop;
    logic       clear_pulse;
    logic       lap_hold;
    logic [1:0] state_o;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    start_stop_ctrl #(.DB_CNT(DB)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn_start),
        .btn_clear  (btn_clear),
        .btn_lap    (btn_lap),
        .start_stop (start_stop),
        .clear_pulse(clear_pulse),
        .lap_hold   (lap_hold),
        .state_o    (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (clear_pulse === 1'b1) pulse_cnt++;
        end
    endtask

    // Hold the given buttons for 20 cycles, release, and let the debouncers settle.
    task automatic hold_btns(input logic s, input logic c, input logic l);
        btn_start = s; btn_clear = c; btn_lap = l;
        tick(20);
        btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        tick(12);
    endtask

    task automatic test_reset;
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL reset_state got %b exp 00", state_o); end
        checks++; if (start_stop !== 1'b0) begin errors++; $display("FAIL reset_start_stop got %b exp 0", start_stop); end
        checks++; if (clear_pulse !== 1'b0) begin errors++; $display("FAIL reset_clear_pulse got %b exp 0", clear_pulse); end
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL reset_lap_hold got %b exp 0", lap_hold); end
    endtask

    task automatic test_start_latency;
        btn_start = 1'b1;
        tick(LAT - 1);
        checks++; if (start_stop !== 1'b0) begin errors++; $display("FAIL start_early got %b exp 0", start_stop); end
        tick(1);
        checks++; if (start_stop !== 1'b1) begin errors++; $display("FAIL start_edge got %b exp 1", start_stop); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL start_state got %b exp 01", state_o); end
        tick(20 - LAT);
        btn_start = 1'b0;
        tick(12);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL held_one_press got %b exp 01", state_o); end
    endtask

    task automatic test_glitch;
        btn_start = 1'b1;
        tick(3);
        btn_start = 1'b0;
        tick(15);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL glitch_state got %b exp 01", state_o); end
        checks++; if (start_stop !== 1'b1) begin errors++; $display("FAIL glitch_start_stop got %b exp 1", start_stop); end
    endtask

    task automatic test_clear;
        pulse_cnt = 0;
        hold_btns(1'b0, 1'b1, 1'b0);
        checks++; if (pulse_cnt !== 0) begin errors++; $display("FAIL clear_in_run_pulses got %0d exp 0", pulse_cnt); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL clear_in_run_state got %b exp 01", state_o); end
        hold_btns(1'b1, 1'b0, 1'b0);
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL pause_state got %b exp 10", state_o); end
        checks++; if (start_stop !== 1'b0) begin errors++; $display("FAIL pause_start_stop got %b exp 0", start_stop); end
        pulse_cnt = 0;
        btn_clear = 1'b1;
        tick(LAT - 1);
        checks++; if (state_o !== 2'b10 || clear_pulse !== 1'b0) begin errors++; $display("FAIL clear_early got state %b pulse %b exp 10/0", state_o, clear_pulse); end
        tick(1);
        checks++; if (state_o !== 2'b00 || clear_pulse !== 1'b1) begin errors++; $display("FAIL clear_edge got state %b pulse %b exp 00/1", state_o, clear_pulse); end
        tick(1);
        checks++; if (clear_pulse !== 1'b0) begin errors++; $display("FAIL clear_one_cycle got %b exp 0", clear_pulse); end
        tick(20 - LAT - 1);
        btn_clear = 1'b0;
        tick(12);
        checks++; if (pulse_cnt !== 1) begin errors++; $display("FAIL clear_pulse_count got %0d exp 1", pulse_cnt); end
        pulse_cnt = 0;
        hold_btns(1'b0, 1'b1, 1'b0);
        checks++; if (pulse_cnt !== 1 || state_o !== 2'b00) begin errors++; $display("FAIL clear_in_idle got pulses %0d state %b exp 1/00", pulse_cnt, state_o); end
    endtask

    task automatic test_simultaneous;
        hold_btns(1'b1, 1'b0, 1'b0);
        hold_btns(1'b1, 1'b0, 1'b0);
        checks++; if (state_o !== 2'b10) begin errors++; $display("FAIL simul_setup got %b exp 10", state_o); end
        pulse_cnt = 0;
        btn_start = 1'b1; btn_clear = 1'b1;
        tick(LAT);
        checks++; if (state_o !== 2'b00 || clear_pulse !== 1'b1) begin errors++; $display("FAIL simul_pause got state %b pulse %b exp 00/1", state_o, clear_pulse); end
        btn_start = 1'b0; btn_clear = 1'b0;
        tick(12);
        hold_btns(1'b1, 1'b0, 1'b0);
        pulse_cnt = 0;
        hold_btns(1'b1, 1'b1, 1'b0);
        checks++; if (state_o !== 2'b10 || pulse_cnt !== 0) begin errors++; $display("FAIL simul_run got state %b pulses %0d exp 10/0", state_o, pulse_cnt); end
    endtask

    task automatic test_reset_mid;
        hold_btns(1'b1, 1'b0, 1'b0);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL rst_setup got %b exp 01", state_o); end
        btn_start = 1'b1;
        tick(4);
        rst = 1'b1; btn_start = 1'b0;
        tick(1);
        rst = 1'b0;
        checks++; if (state_o !== 2'b00 || start_stop !== 1'b0 || clear_pulse !== 1'b0 || lap_hold !== 1'b0) begin
            errors++; $display("FAIL rst_mid_outputs got state %b ss %b cp %b lh %b exp 00/0/0/0", state_o, start_stop, clear_pulse, lap_hold);
        end
        tick(15);
        checks++; if (state_o !== 2'b00 || start_stop !== 1'b0) begin errors++; $display("FAIL rst_aborted_press got state %b ss %b exp 00/0", state_o, start_stop); end
        btn_start = 1'b1; rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(LAT - 1);
        checks++; if (state_o !== 2'b00) begin errors++; $display("FAIL rst_held_early got %b exp 00", state_o); end
        tick(1);
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL rst_held_press got %b exp 01", state_o); end
        tick(12);
        btn_start = 1'b0;
        tick(12);
    endtask

    task automatic test_lap;
`ifdef STOPWATCH_LAP_EN
        hold_btns(1'b0, 1'b0, 1'b1);
        checks++; if (lap_hold !== 1'b1) begin errors++; $display("FAIL lap_first got %b exp 1", lap_hold); end
        hold_btns(1'b0, 1'b0, 1'b1);
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_second got %b exp 0", lap_hold); end
        hold_btns(1'b0, 1'b0, 1'b1);
        hold_btns(1'b1, 1'b0, 1'b0);
        checks++; if (lap_hold !== 1'b1 || state_o !== 2'b10) begin errors++; $display("FAIL lap_into_pause got lh %b state %b exp 1/10", lap_hold, state_o); end
        hold_btns(1'b0, 1'b0, 1'b1);
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_in_pause got %b exp 0", lap_hold); end
        hold_btns(1'b1, 1'b0, 1'b0);
        hold_btns(1'b0, 1'b0, 1'b1);
        hold_btns(1'b1, 1'b0, 1'b0);
        hold_btns(1'b0, 1'b1, 1'b0);
        checks++; if (lap_hold !== 1'b0 || state_o !== 2'b00) begin errors++; $display("FAIL lap_clear_idle got lh %b state %b exp 0/00", lap_hold, state_o); end
        hold_btns(1'b0, 1'b0, 1'b1);
        checks++; if (lap_hold !== 1'b0) begin errors++; $display("FAIL lap_in_idle got %b exp 0", lap_hold); end
`else
        int seen;
        seen = 0;
        btn_lap = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (lap_hold !== 1'b0) seen++;
        end
        btn_lap = 1'b0;
        tick(12);
        hold_btns(1'b0, 1'b0, 1'b1);
        checks++; if (seen !== 0 || lap_hold !== 1'b0) begin errors++; $display("FAIL lap_disabled got nonzero %0d lh %b exp 0/0", seen, lap_hold); end
        checks++; if (state_o !== 2'b01) begin errors++; $display("FAIL lap_disabled_state got %b exp 01", state_o); end
`endif
    endtask

    initial begin
        rst = 1'b1; btn_start = 1'b0; btn_clear = 1'b0; btn_lap = 1'b0;
        test_reset();
        test_start_latency();
        test_glitch();
        test_clear();
        test_simultaneous();
        test_reset_mid();
        test_lap();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
